// File: rtl/coproc_cmd_sequencer.sv
// Command sequencer between the HPS PIO exports and the image coprocessor datapath.
// Captures one instruction per start rising edge, runs it against the pixel memory,
// the processing core or the core reset, and reports completion with a level handshake.
module coproc_cmd_sequencer #(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1048576,
    parameter int unsigned RST_CYC     = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [31:0]       pio_instruct,
    input  logic              pio_start,
    output logic              pio_done,
    output logic              pio_donewrite,
    output logic              cmd_error,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              proc_start,
    output logic [3:0]        proc_alg,
    input  logic              proc_done,
    output logic              core_rst_n
);

    localparam logic [2:0] OpNop     = 3'b000;
    localparam logic [2:0] OpWrite   = 3'b001;
    localparam logic [2:0] OpRead    = 3'b010;
    localparam logic [2:0] OpProcess = 3'b011;
    localparam logic [2:0] OpRstCore = 3'b100;

    // One counter serves both the response timeout and the core-reset hold.
    localparam int unsigned CntMax = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StWr,
        StRdWait,
        StProcWait,
        StCoreRst,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              start_q;
    logic [2:0]        op_q, op_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              donewrite_q, donewrite_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              proc_start_q, proc_start_d;
    logic [3:0]        proc_alg_q, proc_alg_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              accept;

    assign accept = (state_q == StIdle) && pio_start && !start_q;

    // Next-state and next-output decode for the command FSM.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        donewrite_d  = donewrite_q;
        error_d      = error_q;
        rd_data_d    = rd_data_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        proc_alg_d   = proc_alg_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        proc_start_d = 1'b0;
        core_rst_n_d = 1'b1;
        // pio_done lags RESP by one register stage, so it survives one cycle past exit.
        done_d       = (state_q == StResp);

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d     = StDecode;
                    op_d        = pio_instruct[2:0];
                    error_d     = 1'b0;
                    donewrite_d = 1'b0;
                    mem_addr_d  = ADDR_W'(pio_instruct[19:3]);
                    mem_wdata_d = DATA_W'(pio_instruct[27:20]);
                    proc_alg_d  = pio_instruct[31:28];
                end
            end
            StDecode: begin
                cnt_d = '0;
                case (op_q)
                    OpNop:     state_d = StResp;
                    OpWrite: begin
                        state_d  = StWr;
                        mem_we_d = 1'b1;
                    end
                    OpRead: begin
                        state_d  = StRdWait;
                        mem_re_d = 1'b1;
                    end
                    OpProcess: begin
                        state_d      = StProcWait;
                        proc_start_d = 1'b1;
                    end
                    OpRstCore: begin
                        state_d      = StCoreRst;
                        core_rst_n_d = 1'b0;
                    end
                    default: begin
                        state_d = StResp;
                        error_d = 1'b1;
                    end
                endcase
            end
            StWr: begin
                state_d     = StResp;
                donewrite_d = 1'b1;
            end
            StRdWait: begin
                // A response in the final counted cycle still wins over the timeout.
                if (mem_rvalid) begin
                    rd_data_d = mem_rdata;
                    state_d   = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    error_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StProcWait: begin
                if (proc_done) begin
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    error_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCoreRst: begin
                if (cnt_q == CntW'(RST_CYC - 1)) begin
                    state_d = StResp;
                end else begin
                    cnt_d        = cnt_q + CntW'(1);
                    core_rst_n_d = 1'b0;
                end
            end
            StResp: begin
                if (!pio_start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= StIdle;
            // Preset high so a start level held through reset is not seen as an edge.
            start_q      <= 1'b1;
            op_q         <= OpNop;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            donewrite_q  <= 1'b0;
            error_q      <= 1'b0;
            rd_data_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            proc_start_q <= 1'b0;
            proc_alg_q   <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= pio_start;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            donewrite_q  <= donewrite_d;
            error_q      <= error_d;
            rd_data_q    <= rd_data_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            proc_start_q <= proc_start_d;
            proc_alg_q   <= proc_alg_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign pio_done      = done_q;
    assign pio_donewrite = donewrite_q;
    assign cmd_error     = error_q;
    assign rd_data       = rd_data_q;
    assign mem_we        = mem_we_q;
    assign mem_re        = mem_re_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign proc_start    = proc_start_q;
    assign proc_alg      = proc_alg_q;
    assign core_rst_n    = core_rst_n_q;

endmodule
